// File: rtl/quad_enc_pkg.sv
// ---------------------------------------------------------------------------
// quad_enc_pkg
// Shared definitions for the quadrature encoder family (quad_enc receiver and
// quad_enc_emitter transmitter).
//   - phase_to_ab(): 2-bit phase p -> {A, B} with A = p[1], B = p[1] ^ p[0].
//     Stepping p upward gives the forward sequence (A,B) 00 -> 01 -> 11 -> 10.
//   - rate_state_t:  IDLE / DWELL states of the edge-rate limiter.
//   - FWD / REV:     direction encoding used on dir inputs.
// ---------------------------------------------------------------------------
package quad_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } rate_state_t;

  localparam logic FWD = 1'b1;
  localparam logic REV = 1'b0;

  // Gray-code mapping so that successive phases differ in exactly one output.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/quad_enc_emitter_edge_rate_limiter.sv
// ---------------------------------------------------------------------------
// edge_rate_limiter
// Spaces output edges: whenever the limiter is IDLE and request is high it
// grants one edge (combinational grant, same cycle) and then holds off in
// DWELL for max(load_value, 1) cycles. Under a continuous request edges are
// therefore exactly max(load_value,1)+1 cycles apart.
// Ports:
//   clk, resetn  : clock and synchronous active-low reset
//   request      : an edge is waiting to be emitted
//   load_value   : dwell length, sampled only in the cycle an edge is granted
//   grant        : one-cycle permission to emit an edge
//   active       : high while in DWELL
// ---------------------------------------------------------------------------
module edge_rate_limiter
  import quad_enc_pkg::*;
#(
  parameter int DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  request,
  input  logic [DWELL_BITS-1:0] load_value,
  output logic                  grant,
  output logic                  active
);

  rate_state_t           state_reg;
  logic [DWELL_BITS-1:0] count_reg;

  assign grant  = (state_reg == IDLE) && request;
  assign active = (state_reg == DWELL);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            // A zero dwell still costs one cycle so edges never merge.
            count_reg <= (load_value == '0) ? DWELL_BITS'(1) : load_value;
            state_reg <= DWELL;
          end
        end
        DWELL: begin
          if (count_reg <= DWELL_BITS'(1)) begin
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - DWELL_BITS'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/quad_enc_emitter.sv
// ---------------------------------------------------------------------------
// quad_enc_emitter
// Quadrature encoder emulator: turns internal step/dir pulses into
// rate-limited A/B (and optional Z index) outputs. Steps accumulate in a
// signed backlog (pending); the edge_rate_limiter releases one edge at a time
// toward clearing it.
// Ports:
//   clk, resetn           : clock and synchronous active-low reset
//   step, dir             : one count per step rising edge, dir=1 forward
//   enable                : 0 clears the backlog and ignores steps
//   config_min_dwell      : minimum clk cycles between output edges
//   config_index_period   : counts per index revolution (0 = no index)
//   enc_a, enc_b, enc_z   : registered quadrature / index outputs
//   position              : signed count of emitted edges (wraps)
//   pending               : signed backlog still to emit
//   busy                  : limiter in DWELL or backlog non-zero
//   faultn                : sticky low after a step was dropped on saturation
// Build option: define QUAD_ENC_EMIT_INDEX_EN to include the index (Z)
// counter; otherwise enc_z is constant 0 and config_index_period is ignored.
// ---------------------------------------------------------------------------
module quad_enc_emitter
  import quad_enc_pkg::*;
#(
  parameter int PENDING_BITS = 16,
  parameter int DWELL_BITS   = 16,
  parameter int POS_BITS     = 32,
  parameter int INDEX_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           step,
  input  logic                           dir,
  input  logic                           enable,
  input  logic [DWELL_BITS-1:0]          config_min_dwell,
  input  logic [INDEX_BITS-1:0]          config_index_period,
  output logic                           enc_a,
  output logic                           enc_b,
  output logic                           enc_z,
  output logic signed [POS_BITS-1:0]     position,
  output logic signed [PENDING_BITS-1:0] pending,
  output logic                           busy,
  output logic                           faultn
);

  // Backlog arithmetic is done two bits wider so that overflow is visible
  // before truncation.
  localparam int PW = PENDING_BITS + 2;
  localparam logic signed [PW-1:0] PEND_MAX = {3'b000, {(PENDING_BITS-1){1'b1}}};
  localparam logic signed [PW-1:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PW-1:0] PEND_ONE = PW'(1);

  logic                           step_prev_reg;
  logic signed [PENDING_BITS-1:0] pending_reg, pending_next;
  logic [1:0]                     phase_reg, phase_next;
  logic signed [POS_BITS-1:0]     position_reg, position_next;
  logic                           enc_a_reg, enc_b_reg, enc_z_reg, enc_z_next;
  logic                           faultn_reg, fault_set;
  logic                           request, grant, limiter_active;
  logic                           step_edge, emit_dir;
  logic [1:0]                     ab_next;
  logic signed [PW-1:0]           pend_ext, after_emit, with_step;

  // step is generated inside this clock domain, so no synchroniser.
  assign step_edge = step & ~step_prev_reg;
  assign emit_dir  = pending_reg[PENDING_BITS-1] ? REV : FWD;
  assign request   = enable && (pending_reg != '0);

  edge_rate_limiter #(
    .DWELL_BITS (DWELL_BITS)
  ) u_limiter (
    .clk        (clk),
    .resetn     (resetn),
    .request    (request),
    .load_value (config_min_dwell),
    .grant      (grant),
    .active     (limiter_active)
  );

  // Backlog update: a step and an emission in the same cycle both apply.
  // Emission always moves toward zero, so only the step can overflow.
  always_comb begin
    pend_ext   = {{2{pending_reg[PENDING_BITS-1]}}, pending_reg};
    after_emit = pend_ext;
    if (grant) begin
      after_emit = (emit_dir == FWD) ? pend_ext - PEND_ONE : pend_ext + PEND_ONE;
    end
    with_step    = (dir == FWD) ? after_emit + PEND_ONE : after_emit - PEND_ONE;
    pending_next = after_emit[PENDING_BITS-1:0];
    fault_set    = 1'b0;
    if (!enable) begin
      pending_next = '0;
    end else if (step_edge) begin
      if ((with_step > PEND_MAX) || (with_step < PEND_MIN)) begin
        fault_set = 1'b1;
      end else begin
        pending_next = with_step[PENDING_BITS-1:0];
      end
    end
  end

  always_comb begin
    phase_next    = phase_reg;
    position_next = position_reg;
    if (grant) begin
      if (emit_dir == FWD) begin
        phase_next    = phase_reg + 2'd1;
        position_next = position_reg + POS_BITS'(1);
      end else begin
        phase_next    = phase_reg - 2'd1;
        position_next = position_reg - POS_BITS'(1);
      end
    end
    ab_next = phase_to_ab(phase_next);
  end

`ifdef QUAD_ENC_EMIT_INDEX_EN
  logic [INDEX_BITS-1:0] ic_reg, ic_next, period_prev_reg;

  // Index counter tracks position modulo the period; a period change (or a
  // zero period) re-anchors it at 0.
  always_comb begin
    ic_next = ic_reg;
    if ((config_index_period == '0) || (config_index_period != period_prev_reg)) begin
      ic_next = '0;
    end else if (grant) begin
      if (emit_dir == FWD) begin
        ic_next = (ic_reg == config_index_period - INDEX_BITS'(1)) ? '0 : ic_reg + INDEX_BITS'(1);
      end else begin
        ic_next = (ic_reg == '0) ? config_index_period - INDEX_BITS'(1) : ic_reg - INDEX_BITS'(1);
      end
    end
    enc_z_next = (config_index_period != '0) && (ic_next == '0) && (phase_next == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ic_reg          <= '0;
      period_prev_reg <= '0;
    end else begin
      ic_reg          <= ic_next;
      period_prev_reg <= config_index_period;
    end
  end
`else
  logic unused_index;
  assign unused_index = ^config_index_period;
  assign enc_z_next   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      step_prev_reg <= 1'b0;
      pending_reg   <= '0;
      phase_reg     <= 2'd0;
      position_reg  <= '0;
      enc_a_reg     <= 1'b0;
      enc_b_reg     <= 1'b0;
      enc_z_reg     <= 1'b0;
      faultn_reg    <= 1'b1;
    end else begin
      step_prev_reg <= step;
      pending_reg   <= pending_next;
      phase_reg     <= phase_next;
      position_reg  <= position_next;
      enc_a_reg     <= ab_next[1];
      enc_b_reg     <= ab_next[0];
      enc_z_reg     <= enc_z_next;
      if (fault_set) begin
        faultn_reg <= 1'b0;
      end
    end
  end

  assign enc_a    = enc_a_reg;
  assign enc_b    = enc_b_reg;
  assign enc_z    = enc_z_reg;
  assign position = position_reg;
  assign pending  = pending_reg;
  assign busy     = limiter_active || (pending_reg != '0);
  assign faultn   = faultn_reg;

endmodule

// File: tb/tb_quad_enc_emitter.sv
// ---------------------------------------------------------------------------
// tb_quad_enc_emitter
// Directed bench for quad_enc_emitter with a 4-bit backlog (limit +/-7).
// Inputs are driven on the falling clock edge; outputs are sampled either on
// the falling edge or 2 time units after the rising edge by the edge monitor.
// ---------------------------------------------------------------------------
module tb_quad_enc_emitter;

  localparam int PB  = 4;
  localparam int DB  = 16;
  localparam int PSB = 32;
  localparam int IB  = 16;
`ifdef QUAD_ENC_EMIT_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  step = 1'b0;
  logic                  dir = 1'b0;
  logic                  enable = 1'b0;
  logic [DB-1:0]         dwell = 16'd1;
  logic [IB-1:0]         period = 16'd0;
  logic                  enc_a, enc_b, enc_z, busy, faultn;
  logic signed [PSB-1:0] position;
  logic signed [PB-1:0]  pending;

  int checks = 0;
  int failures = 0;

  quad_enc_emitter #(
    .PENDING_BITS (PB),
    .DWELL_BITS   (DB),
    .POS_BITS     (PSB),
    .INDEX_BITS   (IB)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .step                (step),
    .dir                 (dir),
    .enable              (enable),
    .config_min_dwell    (dwell),
    .config_index_period (period),
    .enc_a               (enc_a),
    .enc_b               (enc_b),
    .enc_z               (enc_z),
    .position            (position),
    .pending             (pending),
    .busy                (busy),
    .faultn              (faultn)
  );

  always #5 clk = ~clk;

  // Edge monitor: records A/B changes, their spacing, gray validity,
  // busy falling edges and index pulses while mon_en is set.
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         n_chg, gray_err, min_gap, busy_fall, z_seen, chg_last;
  int         chg_cyc[8];
  logic [1:0] chg_ab[8];
  logic [1:0] ab_prev;
  logic       busy_prev;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (mon_en) begin
        if ({enc_a, enc_b} !== ab_prev) begin
          if (^({enc_a, enc_b} ^ ab_prev) !== 1'b1) gray_err++;
          if (n_chg > 0 && (cyc - chg_last) < min_gap) min_gap = cyc - chg_last;
          if (n_chg < 8) begin
            chg_cyc[n_chg] = cyc;
            chg_ab[n_chg]  = {enc_a, enc_b};
          end
          chg_last = cyc;
          n_chg++;
          ab_prev = {enc_a, enc_b};
        end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
        if (enc_z) z_seen++;
      end
    end
  end

  task automatic mon_start();
    n_chg = 0; gray_err = 0; min_gap = 100000; busy_fall = -1; z_seen = 0; chg_last = 0;
    ab_prev = {enc_a, enc_b};
    busy_prev = busy;
    mon_en = 1'b1;
  endtask

  // Called at a falling edge; step is high across exactly one rising edge.
  task automatic pulse(input logic d);
    step = 1'b1;
    dir  = d;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; step = 1'b0; period = 16'd0;
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (enc_a !== 1'b0) begin failures++; $display("FAIL reset_enc_a: got %b want 0", enc_a); end
    checks++; if (enc_b !== 1'b0) begin failures++; $display("FAIL reset_enc_b: got %b want 0", enc_b); end
    checks++; if (enc_z !== 1'b0) begin failures++; $display("FAIL reset_enc_z: got %b want 0", enc_z); end
    checks++; if (position !== 32'sd0) begin failures++; $display("FAIL reset_position: got %0d want 0", position); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL reset_faultn: got %b want 1", faultn); end
    resetn = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_forward3();
    do_reset();
    dwell = 16'd4; enable = 1'b1; period = 16'd0;
    @(negedge clk);
    mon_start();
    repeat (3) pulse(1'b1);
    repeat (25) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (n_chg !== 3) begin failures++; $display("FAIL fwd3_edges: got %0d want 3", n_chg); end
    checks++; if (chg_ab[0] !== 2'b01) begin failures++; $display("FAIL fwd3_ab0: got %b want 01", chg_ab[0]); end
    checks++; if (chg_ab[1] !== 2'b11) begin failures++; $display("FAIL fwd3_ab1: got %b want 11", chg_ab[1]); end
    checks++; if (chg_ab[2] !== 2'b10) begin failures++; $display("FAIL fwd3_ab2: got %b want 10", chg_ab[2]); end
    checks++; if (chg_cyc[1] - chg_cyc[0] !== 5) begin failures++; $display("FAIL fwd3_gap01: got %0d want 5", chg_cyc[1] - chg_cyc[0]); end
    checks++; if (chg_cyc[2] - chg_cyc[1] !== 5) begin failures++; $display("FAIL fwd3_gap12: got %0d want 5", chg_cyc[2] - chg_cyc[1]); end
    checks++; if (position !== 32'sd3) begin failures++; $display("FAIL fwd3_position: got %0d want 3", position); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL fwd3_pending: got %0d want 0", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fwd3_busy: got %b want 0", busy); end
    checks++; if (busy_fall - chg_cyc[2] !== 4) begin failures++; $display("FAIL fwd3_busy_fall: got %0d want 4", busy_fall - chg_cyc[2]); end
    checks++; if (z_seen !== 0) begin failures++; $display("FAIL fwd3_z: got %0d want 0", z_seen); end
    $display("test_forward3: edges=%0d position=%0d", n_chg, position);
  endtask

  task automatic test_back_to_back();
    do_reset();
    dwell = 16'd2; enable = 1'b1;
    @(negedge clk);
    mon_start();
    repeat (10) pulse(1'b1);
    repeat (4) pulse(1'b0);
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    // 8 forward edges while the backlog drains, then 2 reverse edges.
    checks++; if (position !== 32'sd6) begin failures++; $display("FAIL b2b_position: got %0d want 6", position); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL b2b_pending: got %0d want 0", pending); end
    checks++; if (n_chg !== 10) begin failures++; $display("FAIL b2b_edges: got %0d want 10", n_chg); end
    checks++; if (min_gap !== 3) begin failures++; $display("FAIL b2b_min_gap: got %0d want 3", min_gap); end
    checks++; if (gray_err !== 0) begin failures++; $display("FAIL b2b_gray: got %0d want 0", gray_err); end
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL b2b_faultn: got %b want 1", faultn); end
    $display("test_back_to_back: edges=%0d position=%0d", n_chg, position);
  endtask

  task automatic test_saturation();
    do_reset();
    dwell = 16'd100; enable = 1'b1;
    @(negedge clk);
    // First step is emitted at once, the next seven fill the backlog to +7.
    repeat (8) pulse(1'b1);
    checks++; if (pending !== 4'sd7) begin failures++; $display("FAIL sat_pending_full: got %0d want 7", pending); end
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL sat_faultn_before: got %b want 1", faultn); end
    checks++; if (position !== 32'sd1) begin failures++; $display("FAIL sat_position: got %0d want 1", position); end
    pulse(1'b1);
    checks++; if (pending !== 4'sd7) begin failures++; $display("FAIL sat_pending_clamp: got %0d want 7", pending); end
    checks++; if (faultn !== 1'b0) begin failures++; $display("FAIL sat_faultn_after: got %b want 0", faultn); end
    pulse(1'b1);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL sat_disable_pending: got %0d want 0", pending); end
    checks++; if (faultn !== 1'b0) begin failures++; $display("FAIL sat_faultn_sticky: got %b want 0", faultn); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sat_busy_dwell: got %b want 1", busy); end
    do_reset();
    @(negedge clk);
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL sat_faultn_cleared: got %b want 1", faultn); end
    $display("test_saturation: done");
  endtask

  task automatic test_enable_drop();
    do_reset();
    dwell = 16'd20; enable = 1'b1;
    @(negedge clk);
    repeat (6) pulse(1'b1);
    checks++; if (pending !== 4'sd5) begin failures++; $display("FAIL en_pending5: got %0d want 5", pending); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL en_pending_clear: got %0d want 0", pending); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_dwell_running: got %b want 1", busy); end
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_dwell_done: got %b want 0", busy); end
    pulse(1'b1);
    pulse(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (position !== 32'sd1) begin failures++; $display("FAIL en_position_hold: got %0d want 1", position); end
    checks++; if ({enc_a, enc_b} !== 2'b01) begin failures++; $display("FAIL en_ab_hold: got %b want 01", {enc_a, enc_b}); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL en_steps_ignored: got %0d want 0", pending); end
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL en_faultn: got %b want 1", faultn); end
    enable = 1'b1;
    pulse(1'b1);
    repeat (2) @(negedge clk);
    checks++; if (position !== 32'sd2) begin failures++; $display("FAIL en_resume_position: got %0d want 2", position); end
    checks++; if ({enc_a, enc_b} !== 2'b11) begin failures++; $display("FAIL en_resume_ab: got %b want 11", {enc_a, enc_b}); end
    $display("test_enable_drop: position=%0d", position);
  endtask

  task automatic test_reset_mid();
    do_reset();
    dwell = 16'd3; enable = 1'b1;
    @(negedge clk);
    repeat (4) pulse(1'b1);
    checks++; if (position !== 32'sd2) begin failures++; $display("FAIL mid_position_pre: got %0d want 2", position); end
    checks++; if (pending !== 4'sd2) begin failures++; $display("FAIL mid_pending_pre: got %0d want 2", pending); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if ({enc_a, enc_b} !== 2'b00) begin failures++; $display("FAIL mid_ab: got %b want 00", {enc_a, enc_b}); end
    checks++; if (position !== 32'sd0) begin failures++; $display("FAIL mid_position: got %0d want 0", position); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL mid_pending: got %0d want 0", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
    resetn = 1'b1;
    $display("test_reset_mid: done");
  endtask

  task automatic test_index();
    bit exp_z;
    period = 16'd8;
    do_reset();
    dwell = 16'd1; enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (enc_z !== IDX_EN) begin failures++; $display("FAIL idx_home: got %b want %b", enc_z, IDX_EN); end
    for (int k = 1; k <= 16; k++) begin
      pulse(1'b1);
      @(negedge clk);
      exp_z = IDX_EN && (k % 8 == 0);
      checks++; if (position !== k || enc_z !== exp_z) begin failures++; $display("FAIL idx_fwd: pos %0d z %b want pos %0d z %b", position, enc_z, k, exp_z); end
    end
    for (int k = 15; k >= 0; k--) begin
      pulse(1'b0);
      @(negedge clk);
      exp_z = IDX_EN && (k % 8 == 0);
      checks++; if (position !== k || enc_z !== exp_z) begin failures++; $display("FAIL idx_rev: pos %0d z %b want pos %0d z %b", position, enc_z, k, exp_z); end
    end
    period = 16'd0;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      pulse(1'b1);
      @(negedge clk);
      checks++; if (position !== k || enc_z !== 1'b0) begin failures++; $display("FAIL idx_off: pos %0d z %b want pos %0d z 0", position, enc_z, k); end
    end
    $display("test_index: index_enabled=%0d", IDX_EN);
  endtask

  task automatic test_random();
    int exp_pos;
    logic d;
    do_reset();
    dwell = 16'd1; enable = 1'b1;
    @(negedge clk);
    mon_start();
    exp_pos = 0;
    for (int i = 0; i < 300; i++) begin
      d = 1'($urandom_range(0, 1));
      pulse(d);
      exp_pos += d ? 1 : -1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_drain_timeout: busy %b want 0", busy); end
    checks++; if (position !== exp_pos) begin failures++; $display("FAIL rnd_position: got %0d want %0d", position, exp_pos); end
    checks++; if (pending !== 4'sd0) begin failures++; $display("FAIL rnd_pending: got %0d want 0", pending); end
    checks++; if (faultn !== 1'b1) begin failures++; $display("FAIL rnd_faultn: got %b want 1", faultn); end
    checks++; if (gray_err !== 0) begin failures++; $display("FAIL rnd_gray: got %0d want 0", gray_err); end
    checks++; if (min_gap < 2) begin failures++; $display("FAIL rnd_min_gap: got %0d want >=2", min_gap); end
    $display("test_random: position=%0d expected=%0d edges=%0d", position, exp_pos, n_chg);
  endtask

  initial begin
    test_reset();
    test_forward3();
    test_back_to_back();
    test_saturation();
    test_enable_drop();
    test_reset_mid();
    test_index();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
